mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- MEM-stage load/store initiator that drives the byte-addressed, little-endian data memory's port set: RA, WA, Di, Do and MemWr.
- Accepts one load or store request at a time from the pipeline, enforces alignment and range, and builds sub-word stores as word read-modify-write.
- Extracts and sign/zero-extends load data, and returns a one-cycle response pulse.
- The pipeline stalls its MEM stage while req_ready=0.

Parameters:
MEM_BYTES, 256, data memory size in bytes; any access with byte address + access size > MEM_BYTES is an error.
ADDR_W, 32, width of request and memory address buses.

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block idle, request accepted when req_valid&req_ready
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  zero-extend sub-word loads (ignored for word/stores)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores/errors)
resp_err  output  1  misaligned, out-of-range or reserved size; valid with resp_valid
RA  output  ADDR_W  memory read address (word base)
WA  output  ADDR_W  memory write address (word base)
Di  output  32  memory write data
MemWr  output  1  memory write enable
Do  input  32  memory read data, registered: reflects RA from previous edge, old data on same-edge write

Behaviour:
- States: IDLE, LD_READ, LD_DATA, RMW_READ, RMW_WRITE, ST_WRITE, RESP.
- Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0. Latched request cleared. RA=WA=Di=0, MemWr=0. req_ready=0 while rst is high.
- req_ready=1 only in IDLE with rst low.
- Acceptance (edge E0) latches size/we/unsigned/addr/wdata. Word base = {addr[ADDR_W-1:2],2'b00}. Lane = addr[1:0].
- Error check at acceptance:
  - size=11 is an error.
  - A half access with addr[0]=1 is an error.
  - A word access with addr[1:0]!=0 is an error.
  - A range overflow (addr + size bytes > MEM_BYTES) is an error.
  - Error goes to RESP: resp_valid pulse 1 cycle after acceptance, resp_err=1, resp_rdata=0. No memory access, MemWr never asserted.
- Load path:
  - IDLE→LD_READ, with RA=word base.
  - LD_READ→LD_DATA; Do is valid during LD_DATA.
  - In LD_DATA: byte=Do[8*lane+:8], half=Do[16*addr[1]+:16], word=Do. Sign-extend unless req_unsigned. Register into resp_rdata.
  - LD_DATA→RESP. resp_valid=1 in the 3rd cycle after acceptance.
- Word store: IDLE→ST_WRITE with MemWr=1, WA=word base, Di=wdata. ST_WRITE→RESP; resp 2nd cycle after acceptance.
- Sub-word store:
  - IDLE→RMW_READ with RA=word base. RMW_READ→RMW_WRITE.
  - In RMW_WRITE: MemWr=1, WA=word base, Di=Do with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Other bytes unchanged.
  - RMW_WRITE→RESP; resp 3rd cycle after acceptance.
- MemWr is high for exactly one cycle per store and zero otherwise. Di=0 when MemWr=0. RA/WA hold the latched word base.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata/resp_err hold until the next response. resp_rdata=0 for stores.
- Back-to-back: the next request can be accepted the cycle after RESP. A load after a store sees the stored data because the write lands before the next read edge.
- Reset mid-operation:
  - rst high in any state forces MemWr=0 combinationally in that cycle, so no write occurs.
  - Next state is IDLE. The pending request is dropped with no resp_valid.
- req_valid outside IDLE is ignored. Request inputs need not be held after acceptance.

Test Plan:
- Preload mem word 0x10=0x8899AABB. lw 0x10 accepted at cycle 0 → resp_valid at cycle 3, resp_rdata=0x8899AABB, resp_err=0, MemWr never high.
- Sub-word loads of word 0x10:
  - lb 0x13 → 0xFFFFFF88.
  - lbu 0x13 → 0x00000088.
  - lh 0x12 → 0xFFFF8899.
  - lhu 0x10 → 0x0000AABB.
- sb 0x11 wdata=0x12345677 → RA=0x10 cycle 1. Single MemWr cycle 2 with WA=0x10, Di=0x889977BB. resp cycle 3. A following lw 0x10 returns 0x889977BB.
- sw 0x20 wdata=0xDEADBEEF → MemWr only in cycle 1, WA=0x20, Di=0xDEADBEEF. resp_valid cycle 2. req_ready=0 in cycles 1–2.
- Each of the following → resp_err=1 at cycle 1, rdata=0, MemWr=0 throughout:
  - lh 0x11.
  - sw 0x22.
  - size=11.
  - lw 0xFC with MEM_BYTES=256 is legal; lw 0x100 is an error.
- sh 0x12 with rst pulsed during RMW_WRITE → MemWr=0 that cycle, memory unchanged, no resp_valid, req_ready=1 first cycle after rst falls.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator: one request at a time, alignment/range checks,
// sub-word stores as word read-modify-write, sign/zero-extended loads.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] RA,
  output logic [ADDR_W-1:0] WA,
  output logic [31:0]       Di,
  output logic              MemWr,
  input  logic [31:0]       Do
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_READ   = 3'd1,
    LD_DATA   = 3'd2,
    RMW_READ  = 3'd3,
    RMW_WRITE = 3'd4,
    ST_WRITE  = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t            state_r, state_next_s;
  logic [1:0]        size_r;
  logic [1:0]        lane_r;
  logic              uns_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       rdata_r;
  logic              err_r;
  logic              accept_s;
  logic              req_err_s;
  logic              wr_state_s;

  // Misalignment, reserved size, or last byte beyond the memory end.
  function automatic logic access_error(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
    logic [2:0]      nbytes;
    logic            misaligned;
    logic [ADDR_W:0] end_addr;
    case (size)
      2'b00: begin nbytes = 3'd1; misaligned = 1'b0; end
      2'b01: begin nbytes = 3'd2; misaligned = addr[0]; end
      2'b10: begin nbytes = 3'd4; misaligned = addr[1] | addr[0]; end
      default: begin nbytes = 3'd1; misaligned = 1'b1; end
    endcase
    end_addr = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, nbytes};
    return misaligned || (end_addr > MEM_LIMIT);
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept_s  = req_valid && (state_r == IDLE);
  assign req_err_s = access_error(req_size, req_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (req_err_s) begin
            state_next_s = RESP;
          end else if (!req_we) begin
            state_next_s = LD_READ;
          end else if (req_size == 2'b10) begin
            state_next_s = ST_WRITE;
          end else begin
            state_next_s = RMW_READ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LD_READ:   state_next_s = LD_DATA;
      LD_DATA:   state_next_s = RESP;
      RMW_READ:  state_next_s = RMW_WRITE;
      RMW_WRITE: state_next_s = RESP;
      ST_WRITE:  state_next_s = RESP;
      RESP:      state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // Request latch and response data; response fields only change on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_r  <= 2'b00;
      lane_r  <= 2'b00;
      uns_r   <= 1'b0;
      wdata_r <= 32'h0000_0000;
      base_r  <= {ADDR_W{1'b0}};
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        size_r  <= req_size;
        lane_r  <= req_addr[1:0];
        uns_r   <= req_unsigned;
        wdata_r <= req_wdata;
        base_r  <= {req_addr[ADDR_W-1:2], 2'b00};
        if (req_err_s) begin
          rdata_r <= 32'h0000_0000;
          err_r   <= 1'b1;
        end
      end
      if (state_r == LD_DATA) begin
        rdata_r <= load_extract(size_r, lane_r, uns_r, Do);
        err_r   <= 1'b0;
      end
      if (wr_state_s) begin
        rdata_r <= 32'h0000_0000;
        err_r   <= 1'b0;
      end
    end
  end

  // Reset kills any write in the same cycle so an interrupted store never lands.
  assign wr_state_s = (state_r == ST_WRITE) || (state_r == RMW_WRITE);
  assign MemWr      = wr_state_s && !rst;

  // Write data: full word, merged word, or zero when not writing.
  always_comb begin
    Di = 32'h0000_0000;
    if (MemWr) begin
      if (state_r == ST_WRITE) begin
        Di = wdata_r;
      end else begin
        Di = store_merge(size_r, lane_r, Do, wdata_r);
      end
    end else begin
      Di = 32'h0000_0000;
    end
  end

  assign req_ready  = (state_r == IDLE) && !rst;
  assign resp_valid = (state_r == RESP);
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;
  assign RA         = base_r;
  assign WA         = base_r;

endmodule
